// File: rtl/mult3_pkg.sv
// Shared definitions for the multiply-by-three serial link:
// FSM state encoding, frame length and mod-3 remainder arithmetic.
package mult3_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    REM0 = 2'd0,
    REM1 = 2'd1,
    REM2 = 2'd2
  } rem_t;

  // Product of a w-bit operand and 3 needs two extra bits.
  function automatic int frame_len(input int w);
    return w + 2;
  endfunction

  // (2*r + b) mod 3, one serial bit at a time, MSB first.
  function automatic rem_t mod3_step(input rem_t r, input logic b);
    rem_t n;
    case (r)
      REM0:    n = b ? REM1 : REM0;
      REM1:    n = b ? REM0 : REM2;
      REM2:    n = b ? REM2 : REM1;
      default: n = REM0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mult3_serial_tx_if.sv
// Operand handshake plus serial frame bus of the mult3 transmitter.
// master = operand source / frame sink, slave = transmitter.
interface mult3_serial_tx_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out;
  logic             out_valid;
  logic             out_first;
  logic             out_last;
  logic             done;

  modport master (
    output in_valid, in_data,
    input  in_ready, out, out_valid, out_first, out_last, done
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out, out_valid, out_first, out_last, done
  );
endinterface

// File: rtl/mult3_serial_tx_tracker.sv
// Running mod-3 remainder of an MSB-first bit stream. Used by the
// transmitter only when MULT3_SELFCHECK_EN is defined.
// rem reflects the remainder including the current bit when en is high.
module mod3_tracker
  import mult3_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       sbit,
  output logic [1:0] rem
);
  rem_t rem_q, base, nxt;

  // Restart from zero on the frame's first bit, then fold in each bit.
  always_comb begin
    base = clr ? REM0 : rem_q;
    nxt  = en ? mod3_step(base, sbit) : rem_q;
  end

  assign rem = nxt;

  // Hold the running remainder between bits.
  always_ff @(posedge clk) begin
    if (!reset) rem_q <= REM0;
    else        rem_q <= nxt;
  end
endmodule

// File: rtl/mult3_serial_tx.sv
// Serial transmitter: latches an operand, forms operand*3 at full
// WIDTH+2 width and shifts it out MSB-first, one bit per clock.
// Optional self-check (define MULT3_SELFCHECK_EN) tracks the remainder
// of each emitted frame and raises sticky err if a frame is not
// divisible by three.
// WIDTH must match the WIDTH of the connected interface instance.
module mult3_serial_tx
  import mult3_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  mult3_serial_tx_if.slave    bus,
  output logic [1:0]          state,
  output logic                err
);
  localparam int L  = frame_len(WIDTH);
  localparam int CW = $clog2(L);

  state_t         st;
  logic [L-1:0]   sr;
  logic [CW-1:0]  cnt;
  logic [L-1:0]   ext;

  assign ext          = {2'b00, bus.in_data};
  assign bus.in_ready = (st == IDLE) && reset;
  assign state        = st;

  // Frame FSM: load product, shift L bits, pulse done, back to idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      st            <= IDLE;
      sr            <= '0;
      cnt           <= '0;
      bus.out       <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_first <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          bus.out       <= 1'b0;
          bus.out_valid <= 1'b0;
          bus.out_first <= 1'b0;
          bus.out_last  <= 1'b0;
          bus.done      <= 1'b0;
          if (bus.in_valid && bus.in_ready) begin
            sr  <= (ext << 1) + ext;
            cnt <= CW'(L - 1);
            st  <= SHIFT;
          end
        end
        SHIFT: begin
          bus.out       <= sr[L-1];
          bus.out_valid <= 1'b1;
          bus.out_first <= (cnt == CW'(L - 1));
          bus.out_last  <= (cnt == '0);
          bus.done      <= 1'b0;
          sr            <= sr << 1;
          cnt           <= cnt - 1'b1;
          if (cnt == '0) st <= DONE;
        end
        DONE: begin
          bus.out       <= 1'b0;
          bus.out_valid <= 1'b0;
          bus.out_first <= 1'b0;
          bus.out_last  <= 1'b0;
          bus.done      <= 1'b1;
          st            <= IDLE;
        end
        default: begin
          bus.out       <= 1'b0;
          bus.out_valid <= 1'b0;
          bus.out_first <= 1'b0;
          bus.out_last  <= 1'b0;
          bus.done      <= 1'b0;
          st            <= IDLE;
        end
      endcase
    end
  end

`ifdef MULT3_SELFCHECK_EN
  logic [1:0] rem;

  mod3_tracker u_trk (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.out_first),
    .en    (bus.out_valid),
    .sbit  (bus.out),
    .rem   (rem)
  );

  // Latch any frame whose final remainder is non-zero.
  always_ff @(posedge clk) begin
    if (!reset)                                                  err <= 1'b0;
    else if (bus.out_valid && bus.out_last && rem != 2'(REM0))   err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mult3_serial_tx.sv
// Directed bench for mult3_serial_tx (WIDTH=8, frame length 10).
module tb_mult3_serial_tx;
  localparam int W = 8;
  localparam int L = W + 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] state;
  logic       err;

  mult3_serial_tx_if #(.WIDTH(W)) bus();

  mult3_serial_tx #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .state (state),
    .err   (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int ndone  = 0;
  int nlast  = 0;

  logic [L-1:0] fr_q[$];
  int           fr_n[$];
  int           rem_q[$];
  logic [L-1:0] sh;
  int           nb;
  int           r;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame collector and loopback divisibility checker.
  always @(negedge clk) begin
    if (bus.done === 1'b1) ndone++;
    if (bus.out_valid === 1'b1) begin
      if (bus.out_first) begin
        sh = '0; nb = 0; r = 0;
      end
      sh = {sh[L-2:0], bus.out};
      nb++;
      r = (2 * r + int'(bus.out)) % 3;
      if (bus.out_last) begin
        nlast++;
        fr_q.push_back(sh);
        fr_n.push_back(nb);
        rem_q.push_back(r);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Offer an operand; returns at the negedge just after the transfer edge.
  task automatic send(input logic [W-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int i = 0; i < 40 && bus.in_ready !== 1'b1; i++) @(negedge clk);
    chk("send_ready", 32'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_frame(input string tag, input logic [L-1:0] exp);
    for (int i = 0; i < 40 && fr_q.size() == 0; i++) @(negedge clk);
    if (fr_q.size() == 0) chk({tag, "_timeout"}, 32'(fr_q.size()), 1);
    else begin
      chk(tag, 32'(fr_q.pop_front()), 32'(exp));
      chk({tag, "_len"}, 32'(fr_n.pop_front()), L);
      chk({tag, "_div"}, 32'(rem_q.pop_front()), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [L-1:0] exp5;
    logic [L-1:0] ops_exp[4];
    logic [W-1:0] ops[4];
    int c1, n0, d0, l0;

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    reset        = 1'b0;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(state), 0);
    chk("rst_outs", 32'({bus.out, bus.out_valid, bus.out_first, bus.out_last, bus.done}), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_ready", 32'(bus.in_ready), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.in_ready), 1);

    // Operand 5: cycle-exact frame timing
    exp5 = 10'b0000001111;
    send(8'd5);
    chk("k_valid", 32'(bus.out_valid), 0);
    chk("k_state", 32'(state), 1);
    chk("k_ready", 32'(bus.in_ready), 0);
    for (int i = 0; i < L; i++) begin
      @(negedge clk);
      chk($sformatf("f5_v%0d", i), 32'(bus.out_valid), 1);
      chk($sformatf("f5_b%0d", i), 32'(bus.out), 32'(exp5[L-1-i]));
      chk($sformatf("f5_first%0d", i), 32'(bus.out_first), 32'(i == 0));
      chk($sformatf("f5_last%0d", i), 32'(bus.out_last), 32'(i == L - 1));
    end
    @(negedge clk);
    chk("f5_done", 32'(bus.done), 1);
    chk("f5_done_valid", 32'(bus.out_valid), 0);
    chk("f5_done_ready", 32'(bus.in_ready), 1);
    @(negedge clk);
    chk("f5_done_pulse", 32'(bus.done), 0);
    expect_frame("f5", exp5);

    // Operand 255 (largest product)
    send(8'd255);
    expect_frame("f255", 10'b1011111101);

    // Operand 0: ten zero bits, valid throughout
    send(8'd0);
    for (int i = 0; i < L; i++) begin
      @(negedge clk);
      chk($sformatf("f0_v%0d", i), 32'(bus.out_valid), 1);
      chk($sformatf("f0_b%0d", i), 32'(bus.out), 0);
    end
    expect_frame("f0", 10'b0000000000);

    // Back-to-back: in_valid held high with 1 then 2
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd1;
    for (int i = 0; i < 40 && bus.in_ready !== 1'b1; i++) @(negedge clk);
    @(negedge clk);
    c1 = cyc;
    bus.in_data = 8'd2;
    n0 = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.in_ready === 1'b1) break;
      n0++;
      @(negedge clk);
    end
    chk("b2b_ready_low", 32'(n0), L + 1);
    chk("b2b_gap", 32'(cyc + 1 - c1), L + 2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    expect_frame("b2b_1", 10'b0000000011);
    expect_frame("b2b_2", 10'b0000000110);

    // Mid-frame reset on 4th bit of 170 (product 510)
    repeat (2) @(negedge clk);
    d0 = ndone;
    l0 = nlast;
    send(8'd170);
    repeat (4) @(negedge clk);
    chk("mr_bit4_valid", 32'(bus.out_valid), 1);
    chk("mr_bit4", 32'(bus.out), 1);
    reset = 1'b0;
    @(negedge clk);
    chk("mr_valid", 32'(bus.out_valid), 0);
    chk("mr_state", 32'(state), 0);
    chk("mr_ready", 32'(bus.in_ready), 0);
    reset = 1'b1;
    repeat (14) @(negedge clk);
    chk("mr_no_done", 32'(ndone - d0), 0);
    chk("mr_no_last", 32'(nlast - l0), 0);
    chk("mr_no_frame", 32'(fr_q.size()), 0);
    send(8'd7);
    expect_frame("f7", 10'b0000010101);

    // Self-check sweep: err must stay clear, every frame divisible
    ops[0] = 8'd0;   ops_exp[0] = 10'b0000000000;
    ops[1] = 8'd85;  ops_exp[1] = 10'b0011111111;
    ops[2] = 8'd170; ops_exp[2] = 10'b0111111110;
    ops[3] = 8'd255; ops_exp[3] = 10'b1011111101;
    for (int i = 0; i < 4; i++) begin
      send(ops[i]);
      expect_frame($sformatf("sc%0d", i), ops_exp[i]);
      chk($sformatf("sc_err%0d", i), 32'(err), 0);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
